// File: rtl/hopfield_spike_decoder.sv
// Rate decoder for the Hopfield spike interface: counts spikes per neuron over a window and
// emits the recalled binary pattern via valid/ready. Optional HOPFIELD_DEC_STABLE_EN adds a convergence flag.
module hopfield_spike_decoder #(
  parameter int N_NEURONS      = 7,
  parameter int WINDOW         = 16,
  parameter int THRESH         = 8,
  parameter int STABLE_WINDOWS = 3,
  localparam int AW            = $clog2(N_NEURONS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 continuous,
  input  logic [N_NEURONS-1:0] spikes,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [N_NEURONS-1:0] out_pattern,
  output logic [AW-1:0]        out_active,
  output logic                 busy,
  output logic                 stable
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int WW = $clog2(WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic [AW-1:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [AW-1:0] acc;
    acc = {AW{1'b0}};
    for (int i = 0; i < N_NEURONS; i++) begin
      acc = acc + AW'(v[i]);
    end
    return acc;
  endfunction

  state_t                          state_r, state_s;
  logic [N_NEURONS-1:0][CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic [WW-1:0]                   win_r, win_s;
  logic                            valid_r, valid_s;
  logic [N_NEURONS-1:0]            pattern_r, pattern_s, pat_new_s;
  logic [AW-1:0]                   active_r, active_s;
  logic                            busy_s;
  logic                            done_s;
  logic                            restart_s;

  // Next-state, counter and result logic for the decode FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    win_s     = win_r;
    valid_s   = valid_r;
    pattern_s = pattern_r;
    active_s  = active_r;
    done_s    = 1'b0;
    restart_s = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      cnt_inc_s[i] = cnt_r[i] + CW'(spikes[i]);
      pat_new_s[i] = (cnt_inc_s[i] >= CW'(THRESH));
    end
    if (clear) begin
      state_s = ST_IDLE;
      valid_s = 1'b0;
      cnt_s   = '0;
      win_s   = {WW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s   = ST_COUNT;
            cnt_s     = '0;
            win_s     = {WW{1'b0}};
            restart_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_COUNT: begin
          cnt_s = cnt_inc_s;
          // The final sample of the window is folded in through cnt_inc_s.
          if (win_r == WW'(WINDOW - 1)) begin
            done_s    = 1'b1;
            pattern_s = pat_new_s;
            active_s  = popcount(pat_new_s);
            valid_s   = 1'b1;
            win_s     = {WW{1'b0}};
            state_s   = ST_HOLD;
          end else begin
            win_s = win_r + WW'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            valid_s = 1'b0;
            cnt_s   = '0;
            win_s   = {WW{1'b0}};
            if (continuous) begin
              state_s = ST_COUNT;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          cnt_s   = '0;
          win_s   = {WW{1'b0}};
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      win_r     <= {WW{1'b0}};
      valid_r   <= 1'b0;
      pattern_r <= {N_NEURONS{1'b0}};
      active_r  <= {AW{1'b0}};
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      win_r     <= win_s;
      valid_r   <= valid_s;
      pattern_r <= pattern_s;
      active_r  <= active_s;
      busy      <= busy_s;
    end
  end

  assign out_valid   = valid_r;
  assign out_pattern = pattern_r;
  assign out_active  = active_r;

`ifdef HOPFIELD_DEC_STABLE_EN
  localparam int SW = $clog2(STABLE_WINDOWS + 1);

  logic [N_NEURONS-1:0] prev_r, prev_s;
  logic [SW-1:0]        match_r, match_s;
  logic                 stable_r, stable_s;

  // Match history: counts identical consecutive windows, saturating.
  always_comb begin
    prev_s   = prev_r;
    match_s  = match_r;
    stable_s = stable_r;
    if (clear || restart_s) begin
      match_s  = {SW{1'b0}};
      stable_s = 1'b0;
    end else if (done_s) begin
      prev_s = pat_new_s;
      if (pat_new_s == prev_r) begin
        if (match_r == SW'(STABLE_WINDOWS)) begin
          match_s = match_r;
        end else begin
          match_s = match_r + SW'(1);
        end
      end else begin
        match_s = SW'(1);
      end
      stable_s = (match_s == SW'(STABLE_WINDOWS));
    end else begin
      stable_s = stable_r;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r   <= {N_NEURONS{1'b0}};
      match_r  <= {SW{1'b0}};
      stable_r <= 1'b0;
    end else begin
      prev_r   <= prev_s;
      match_r  <= match_s;
      stable_r <= stable_s;
    end
  end

  assign stable = stable_r;
`else
  logic unused_s;
  assign unused_s = done_s ^ restart_s;
  assign stable   = 1'b0;
`endif

endmodule

// File: tb/tb_hopfield_spike_decoder.sv
// Directed self-checking bench for hopfield_spike_decoder (expected stable follows HOPFIELD_DEC_STABLE_EN).
module tb_hopfield_spike_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       continuous;
  logic [6:0] spikes;
  logic       out_ready;
  logic       out_valid;
  logic [6:0] out_pattern;
  logic [2:0] out_active;
  logic       busy;
  logic       stable;

  int total = 0;
  int bad   = 0;
  logic en_stable;
  logic exp_st;

  hopfield_spike_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .continuous (continuous),
    .spikes     (spikes),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pattern(out_pattern),
    .out_active (out_active),
    .busy       (busy),
    .stable     (stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
`ifdef HOPFIELD_DEC_STABLE_EN
    en_stable = 1'b1;
`else
    en_stable = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; continuous = 1'b0;
    spikes = 7'h00; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_pattern", out_pattern, 0);
    chk("rst_active", out_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stable", stable, 0);
    rst_n = 1'b1;
    tick();

    // 1: all neurons spiking, valid on edge 17 counting the start edge as 1
    spikes = 7'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    repeat (15) tick();
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_pattern", out_pattern, 7'h7F);
    chk("t1_active", out_active, 7);

    // 3: hold with out_ready low while spikes toggle
    for (int k = 0; k < 5; k++) begin
      spikes = (k % 2 == 0) ? 7'h00 : 7'h2A;
      tick();
    end
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_pattern", out_pattern, 7'h7F);
    chk("t3_hold_busy", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_hs_valid", out_valid, 0);
    chk("t3_hs_busy", busy, 0);
    chk("t3_retain", out_pattern, 7'h7F);

    // 2: threshold boundary, neuron0 8/16, neuron1 7/16
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      spikes = {5'b00000, (k < 7) ? 1'b1 : 1'b0, (k < 8) ? 1'b1 : 1'b0};
      tick();
    end
    chk("t2_valid", out_valid, 1);
    chk("t2_pattern", out_pattern, 7'h01);
    chk("t2_active", out_active, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 4: continuous windows of 7'h55, then 7'h2A
    continuous = 1'b1; out_ready = 1'b1; spikes = 7'h55; start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      repeat ((w == 0) ? 16 : 17) tick();
      exp_st = en_stable & (w == 2);
      chk("t4_valid", out_valid, 1);
      chk("t4_pattern", out_pattern, 7'h55);
      chk("t4_active", out_active, 4);
      chk("t4_stable", stable, exp_st);
    end
    spikes = 7'h2A;
    repeat (17) tick();
    chk("t4_chg_valid", out_valid, 1);
    chk("t4_chg_pattern", out_pattern, 7'h2A);
    chk("t4_chg_stable", stable, 0);
    continuous = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_busy", busy, 0);

    // 5: clear with start at window cycle 9
    spikes = 7'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_stable", stable, 0);
    repeat (20) tick();
    chk("t5_no_valid", out_valid, 0);
    chk("t5_pattern_kept", out_pattern, 7'h2A);

    // 6: reset during HOLD, then a fresh decode
    spikes = 7'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t6_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pattern", out_pattern, 0);
    chk("t6_rst_active", out_active, 0);
    chk("t6_rst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t6_fresh_valid", out_valid, 1);
    chk("t6_fresh_pattern", out_pattern, 7'h0F);
    chk("t6_fresh_active", out_active, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
